// File: rtl/apu_pkg.sv
// Shared APU constants and helpers for the envelope bank.
package apu_pkg;

    // Default width of param, divider, decay counter and volume.
    localparam int ENV_VOL_W = 4;

    // Terminal (maximum) envelope value for a given volume width.
    function automatic int env_max(input int vol_w);
        return (1 << vol_w) - 1;
    endfunction

endpackage

// File: rtl/envelope_bank_if.sv
// Per-channel control and status bundle between the register/frame logic and the envelope bank.
interface envelope_bank_if
    import apu_pkg::*;
#(
    parameter int CH    = 3,
    parameter int VOL_W = ENV_VOL_W
);
    logic                      cpu_en;
    logic                      quarter_frame;
    logic [CH-1:0]             loop;
    logic [CH-1:0]             constant_volume;
    logic [CH-1:0]             rise;
    logic [CH-1:0]             start;
    logic [CH-1:0][VOL_W-1:0]  param;
    logic [CH-1:0][VOL_W-1:0]  volume;
    logic [CH-1:0]             done;

    modport master (
        output cpu_en, quarter_frame, loop, constant_volume, rise, start, param,
        input  volume, done
    );

    modport slave (
        input  cpu_en, quarter_frame, loop, constant_volume, rise, start, param,
        output volume, done
    );
endinterface

// File: rtl/envelope_channel.sv
// One envelope unit: start flag, period divider and decay/attack counter.
module envelope_channel
    import apu_pkg::*;
#(
    parameter int VOL_W = ENV_VOL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpu_en,
    input  logic             quarter_frame,
    input  logic             loop,
    input  logic             constant_volume,
    input  logic             rise,
    input  logic             start,
    input  logic [VOL_W-1:0] param,
    output logic [VOL_W-1:0] volume,
    output logic             done
);
    localparam logic [VOL_W-1:0] MAX = VOL_W'(env_max(VOL_W));

    logic             start_flg_reg, start_flg_next;
    logic [VOL_W-1:0] divider_reg, divider_next;
    logic [VOL_W-1:0] decay_reg, decay_next;

    // Next-state: a pending start reloads on the next quarter frame, otherwise the divider
    // paces steps of the decay counter; wrap only happens through the loop flag.
    always_comb begin
        start_flg_next = start_flg_reg;
        divider_next   = divider_reg;
        decay_next     = decay_reg;
        if (cpu_en) begin
            if (start) begin
                start_flg_next = 1'b1;
            end else if (quarter_frame) begin
                start_flg_next = 1'b0;
            end
            if (quarter_frame) begin
                if (start_flg_reg) begin
                    divider_next = param;
                    decay_next   = rise ? '0 : MAX;
                end else if (divider_reg == '0) begin
                    divider_next = param;
                    if (rise) begin
                        if (decay_reg != MAX) begin
                            decay_next = decay_reg + 1'b1;
                        end else if (loop) begin
                            decay_next = '0;
                        end
                    end else begin
                        if (decay_reg != '0) begin
                            decay_next = decay_reg - 1'b1;
                        end else if (loop) begin
                            decay_next = MAX;
                        end
                    end
                end else begin
                    divider_next = divider_reg - 1'b1;
                end
            end
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_flg_reg <= 1'b0;
            divider_reg   <= '0;
            decay_reg     <= '0;
        end else begin
            start_flg_reg <= start_flg_next;
            divider_reg   <= divider_next;
            decay_reg     <= decay_next;
        end
    end

    // Outputs: constant volume bypasses the counter; done flags a parked, non-looping envelope.
    always_comb begin
        volume = constant_volume ? param : decay_reg;
        done   = !loop && !start_flg_reg && (decay_reg == (rise ? MAX : '0));
    end
endmodule

// File: rtl/envelope_bank.sv
// Bank of independent envelope channels sharing clock, cpu_en and quarter-frame tick.
module envelope_bank
    import apu_pkg::*;
#(
    parameter int CH    = 3,
    parameter int VOL_W = ENV_VOL_W
) (
    input  logic           clk,
    input  logic           rst_n,
    envelope_bank_if.slave bus
);
    logic [CH-1:0][VOL_W-1:0] volume_w;
    logic [CH-1:0]            done_w;

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            envelope_channel #(
                .VOL_W(VOL_W)
            ) u_channel (
                .clk             (clk),
                .rst_n           (rst_n),
                .cpu_en          (bus.cpu_en),
                .quarter_frame   (bus.quarter_frame),
                .loop            (bus.loop[gi]),
                .constant_volume (bus.constant_volume[gi]),
                .rise            (bus.rise[gi]),
                .start           (bus.start[gi]),
                .param           (bus.param[gi]),
                .volume          (volume_w[gi]),
                .done            (done_w[gi])
            );
        end
    endgenerate

    assign bus.volume = volume_w;
    assign bus.done   = done_w;
endmodule

// File: tb/tb_envelope_bank.sv
// Randomised and directed check of two envelope_bank configurations against a behavioural model.
module tb_envelope_bank;
    localparam int NI = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    envelope_bank_if #(.CH(3), .VOL_W(4)) bus_a ();
    envelope_bank_if #(.CH(4), .VOL_W(6)) bus_b ();

    envelope_bank #(.CH(3), .VOL_W(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    envelope_bank #(.CH(4), .VOL_W(6)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    // stimulus
    int chn [NI] = '{3, 4};
    int mx  [NI] = '{15, 63};
    bit cpu_en_s, qf_s;
    int lp [NI][4];
    int cv [NI][4];
    int rs [NI][4];
    int st [NI][4];
    int pm [NI][4];
    // reference model state
    int flg [NI][4];
    int dv  [NI][4];
    int dc  [NI][4];

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus_a.cpu_en = cpu_en_s;
        bus_a.quarter_frame = qf_s;
        bus_b.cpu_en = cpu_en_s;
        bus_b.quarter_frame = qf_s;
        for (int c = 0; c < 3; c++) begin
            bus_a.loop[c]            = (lp[0][c] != 0);
            bus_a.constant_volume[c] = (cv[0][c] != 0);
            bus_a.rise[c]            = (rs[0][c] != 0);
            bus_a.start[c]           = (st[0][c] != 0);
            bus_a.param[c]           = 4'(pm[0][c]);
        end
        for (int c = 0; c < 4; c++) begin
            bus_b.loop[c]            = (lp[1][c] != 0);
            bus_b.constant_volume[c] = (cv[1][c] != 0);
            bus_b.rise[c]            = (rs[1][c] != 0);
            bus_b.start[c]           = (st[1][c] != 0);
            bus_b.param[c]           = 6'(pm[1][c]);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NI; i++)
            for (int c = 0; c < 4; c++) begin
                flg[i][c] = 0;
                dv[i][c]  = 0;
                dc[i][c]  = 0;
            end
    endfunction

    // One clock edge of the envelope rules, written directly from the behaviour description.
    function automatic void model_update();
        int old_flg;
        if (!rst_n) begin
            model_clear();
            return;
        end
        if (!cpu_en_s) return;
        for (int i = 0; i < NI; i++)
            for (int c = 0; c < chn[i]; c++) begin
                old_flg = flg[i][c];
                if (st[i][c] != 0) flg[i][c] = 1;
                else if (qf_s) flg[i][c] = 0;
                if (!qf_s) continue;
                if (old_flg != 0) begin
                    dv[i][c] = pm[i][c];
                    dc[i][c] = (rs[i][c] != 0) ? 0 : mx[i];
                end else if (dv[i][c] > 0) begin
                    dv[i][c] = dv[i][c] - 1;
                end else begin
                    dv[i][c] = pm[i][c];
                    if (rs[i][c] != 0) begin
                        if (dc[i][c] < mx[i]) dc[i][c] = dc[i][c] + 1;
                        else if (lp[i][c] != 0) dc[i][c] = 0;
                    end else begin
                        if (dc[i][c] > 0) dc[i][c] = dc[i][c] - 1;
                        else if (lp[i][c] != 0) dc[i][c] = mx[i];
                    end
                end
            end
    endfunction

    task automatic check_outputs(input string phase);
        int ev, ed, ov, od;
        for (int i = 0; i < NI; i++)
            for (int c = 0; c < chn[i]; c++) begin
                ev = (cv[i][c] != 0) ? pm[i][c] : dc[i][c];
                ed = (lp[i][c] == 0 && flg[i][c] == 0 &&
                      dc[i][c] == ((rs[i][c] != 0) ? mx[i] : 0)) ? 1 : 0;
                ov = (i == 0) ? int'(bus_a.volume[c]) : int'(bus_b.volume[c]);
                od = (i == 0) ? int'(bus_a.done[c])   : int'(bus_b.done[c]);
                check_val($sformatf("%s vol i%0d c%0d", phase, i, c), ov, ev);
                check_val($sformatf("%s done i%0d c%0d", phase, i, c), od, ed);
            end
    endtask

    task automatic run_cycle(input string phase);
        @(negedge clk);
        drive();
        #1;
        check_outputs(phase);
        @(posedge clk);
        model_update();
    endtask

    task automatic set_all(input int l, input int c_v, input int r, input int p);
        for (int i = 0; i < NI; i++)
            for (int c = 0; c < 4; c++) begin
                lp[i][c] = l;
                cv[i][c] = c_v;
                rs[i][c] = r;
                pm[i][c] = p;
                st[i][c] = 0;
            end
    endtask

    task automatic set_loop(input int l);
        for (int i = 0; i < NI; i++)
            for (int c = 0; c < 4; c++) lp[i][c] = l;
    endtask

    task automatic start_all(input string phase);
        for (int i = 0; i < NI; i++)
            for (int c = 0; c < 4; c++) st[i][c] = 1;
        cpu_en_s = 1'b1;
        qf_s = 1'b0;
        run_cycle(phase);
        for (int i = 0; i < NI; i++)
            for (int c = 0; c < 4; c++) st[i][c] = 0;
    endtask

    // n quarter frames, one every 4 enabled cycles
    task automatic run_qf(input int n, input string phase);
        cpu_en_s = 1'b1;
        repeat (n) begin
            qf_s = 1'b0;
            repeat (3) run_cycle(phase);
            qf_s = 1'b1;
            run_cycle(phase);
        end
        qf_s = 1'b0;
    endtask

    // Explicit check on channel 0 of the 4-bit instance, taken between edges.
    task automatic check_a0(input string tag, input int ev, input int ed);
        @(negedge clk);
        drive();
        #1;
        check_val({tag, " vol"}, int'(bus_a.volume[0]), ev);
        check_val({tag, " done"}, int'(bus_a.done[0]), ed);
    endtask

    // Asynchronous reset asserted between clock edges, held across two edges, released between edges.
    task automatic do_reset(input bit chk_idle);
        @(negedge clk);
        drive();
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_outputs("async_rst");
        if (chk_idle) begin
            check_val("rst_idle vol", int'(bus_a.volume[0]), 0);
            check_val("rst_idle done", int'(bus_a.done[0]), 1);
        end
        @(posedge clk);
        model_update();
        run_cycle("rst_hold");
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        cpu_en_s = 1'b0;
        qf_s = 1'b0;
        set_all(0, 0, 0, 0);
        model_clear();
        drive();
        run_cycle("por");
        run_cycle("por");
        check_a0("por", 0, 1);
        #2;
        rst_n = 1'b1;

        // falling decay, param=2
        set_all(0, 0, 0, 2);
        start_all("fall");
        run_qf(1, "fall");
        check_a0("fall_first", 15, 0);
        run_qf(45, "fall");
        check_a0("fall_zero", 0, 1);
        run_qf(6, "fall_hold");
        check_a0("fall_hold", 0, 1);
        set_loop(1);
        run_qf(3, "fall_loop");
        check_a0("fall_wrap", 15, 0);

        // mid-run reset at decay 7
        set_all(0, 0, 0, 2);
        start_all("rst_seq");
        run_qf(25, "rst_seq");
        check_a0("pre_rst", 7, 0);
        do_reset(1'b1);

        // rising mode, param=0
        set_all(0, 0, 1, 0);
        start_all("rise");
        run_qf(1, "rise");
        check_a0("rise_first", 0, 0);
        run_qf(15, "rise");
        check_a0("rise_top", 15, 1);
        set_loop(1);
        run_qf(1, "rise_loop");
        check_a0("rise_wrap", 0, 0);

        // start colliding with a quarter frame at decay 5, divider 0
        set_all(0, 0, 0, 0);
        start_all("coll");
        run_qf(11, "coll");
        check_a0("coll_pre", 5, 0);
        for (int i = 0; i < NI; i++)
            for (int c = 0; c < 4; c++) st[i][c] = 1;
        cpu_en_s = 1'b1;
        qf_s = 1'b1;
        run_cycle("coll");
        for (int i = 0; i < NI; i++)
            for (int c = 0; c < 4; c++) st[i][c] = 0;
        qf_s = 1'b0;
        check_a0("coll_step", 4, 0);
        run_qf(1, "coll");
        check_a0("coll_reload", 15, 0);

        // cpu_en gating
        cpu_en_s = 1'b0;
        for (int i = 0; i < NI; i++)
            for (int c = 0; c < 4; c++) st[i][c] = 1;
        run_cycle("gate");
        for (int i = 0; i < NI; i++)
            for (int c = 0; c < 4; c++) st[i][c] = 0;
        qf_s = 1'b1;
        repeat (3) run_cycle("gate");
        qf_s = 1'b0;
        check_a0("gate_frozen", 15, 0);
        cpu_en_s = 1'b1;
        qf_s = 1'b1;
        run_cycle("gate");
        qf_s = 1'b0;
        check_a0("gate_step", 14, 0);

        // channel independence, constant volume on one wide channel
        set_all(0, 0, 0, 1);
        cv[1][2] = 1;
        pm[1][2] = 42;
        start_all("indep");
        run_qf(5, "indep");
        st[1][0] = 1;
        st[0][1] = 1;
        cpu_en_s = 1'b1;
        qf_s = 1'b0;
        run_cycle("indep");
        st[1][0] = 0;
        st[0][1] = 0;
        run_qf(3, "indep");
        @(negedge clk);
        drive();
        #1;
        check_val("indep const vol", int'(bus_b.volume[2]), 42);

        // randomised phase
        for (int n = 0; n < 3000; n++) begin
            cpu_en_s = ($urandom % 4) != 0;
            qf_s = ($urandom % 3) == 0;
            for (int i = 0; i < NI; i++)
                for (int c = 0; c < 4; c++) begin
                    st[i][c] = (($urandom % 25) == 0) ? 1 : 0;
                    if (($urandom % 60) == 0) lp[i][c] = $urandom % 2;
                    if (($urandom % 80) == 0) rs[i][c] = $urandom % 2;
                    if (($urandom % 100) == 0) cv[i][c] = $urandom % 2;
                    if (($urandom % 70) == 0) pm[i][c] = $urandom_range(0, mx[i]) % 4;
                    if (($urandom % 300) == 0) pm[i][c] = $urandom_range(0, mx[i]);
                end
            if (($urandom % 500) == 0) do_reset(1'b0);
            else run_cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
